// File: rtl/thread_issue_arbiter.sv
// rtl/thread_issue_arbiter.sv - round-robin issue of requester instructions onto a shared pool of thread lanes
// Each lane walks IDLE -> EXEC -> HOLD -> IDLE; held results drain round-robin to writeback.
module thread_issue_arbiter #(
  parameter int W        = 32,
  parameter int NUM_REQ  = 4,
  parameter int NUM_LANE = 4,
  parameter int RID_W    = $clog2(NUM_REQ),
  parameter int LID_W    = $clog2(NUM_LANE)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*6-1:0]    req_opcode,
  input  logic [NUM_REQ-1:0]      req_is_fp,
  input  logic [NUM_REQ*W-1:0]    req_op1,
  input  logic [NUM_REQ*W-1:0]    req_op2,
  output logic [NUM_LANE-1:0]     lane_valid,
  output logic [5:0]              lane_opcode,
  output logic                    lane_is_fp,
  output logic [W-1:0]            lane_op1,
  output logic [W-1:0]            lane_op2,
  input  logic [NUM_LANE-1:0]     lane_ready,
  input  logic [NUM_LANE-1:0]     lane_done,
  input  logic [NUM_LANE*W-1:0]   lane_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [W-1:0]            rsp_result,
  output logic [RID_W-1:0]        rsp_req_id,
  output logic [LID_W-1:0]        rsp_lane_id,
  output logic [LID_W:0]          busy_count,
  output logic                    err_spurious
);

  localparam int CW = LID_W + 1;

  typedef enum logic [1:0] {
    LANE_IDLE = 2'd0,
    LANE_EXEC = 2'd1,
    LANE_HOLD = 2'd2
  } lane_state_e;

  lane_state_e          lane_state_q [NUM_LANE];
  lane_state_e          lane_state_d [NUM_LANE];
  logic [RID_W-1:0]     lane_rid_q   [NUM_LANE];
  logic [RID_W-1:0]     lane_rid_d   [NUM_LANE];
  logic [W-1:0]         lane_res_q   [NUM_LANE];
  logic [W-1:0]         lane_res_d   [NUM_LANE];

  logic [RID_W-1:0]     gnt_ptr_q, gnt_ptr_d;
  logic [LID_W-1:0]     drn_ptr_q, drn_ptr_d;
  logic                 err_q, err_d;

  logic [NUM_LANE-1:0]  lane_valid_q, lane_valid_d;
  logic [5:0]           lane_opcode_q, lane_opcode_d;
  logic                 lane_is_fp_q, lane_is_fp_d;
  logic [W-1:0]         lane_op1_q, lane_op1_d;
  logic [W-1:0]         lane_op2_q, lane_op2_d;

  logic [NUM_LANE-1:0]  lane_free;
  logic [LID_W-1:0]     tgt_lane;
  logic                 req_any;
  logic [RID_W-1:0]     gnt_idx;
  logic [RID_W-1:0]     req_cand;
  logic                 issue_fire;

  logic                 hold_any;
  logic [LID_W-1:0]     drn_idx;
  logic [LID_W-1:0]     lane_cand;
  logic                 drain_fire;
  logic [CW-1:0]        busy_cnt;

  // Issue target: lowest-index lane that is IDLE and whose lane reports ready.
  always_comb begin
    lane_free = '0;
    tgt_lane  = '0;
    for (int l = 0; l < NUM_LANE; l++) begin
      lane_free[l] = (lane_state_q[l] == LANE_IDLE) && lane_ready[l];
    end
    for (int l = NUM_LANE - 1; l >= 0; l--) begin
      if (lane_free[l]) tgt_lane = LID_W'(l);
    end
  end

  always_comb begin
    req_any  = 1'b0;
    gnt_idx  = '0;
    req_cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_cand = gnt_ptr_q + RID_W'(k);
      if (!req_any && req_valid[req_cand]) begin
        req_any = 1'b1;
        gnt_idx = req_cand;
      end
    end
  end

  // rst_n gates the grant so no requester is told it was accepted while reset is held.
  assign issue_fire = rst_n && req_any && (|lane_free);

  always_comb begin
    req_ready = '0;
    if (issue_fire) req_ready = NUM_REQ'(1) << gnt_idx;
  end

  always_comb begin
    hold_any  = 1'b0;
    drn_idx   = '0;
    lane_cand = '0;
    for (int k = 0; k < NUM_LANE; k++) begin
      lane_cand = drn_ptr_q + LID_W'(k);
      if (!hold_any && (lane_state_q[lane_cand] == LANE_HOLD)) begin
        hold_any = 1'b1;
        drn_idx  = lane_cand;
      end
    end
  end

  assign drain_fire  = hold_any && rsp_ready;
  assign rsp_valid   = hold_any;
  assign rsp_result  = hold_any ? lane_res_q[drn_idx] : '0;
  assign rsp_req_id  = hold_any ? lane_rid_q[drn_idx] : '0;
  assign rsp_lane_id = hold_any ? drn_idx : '0;

  always_comb begin
    err_d = err_q;
    for (int l = 0; l < NUM_LANE; l++) begin
      lane_state_d[l] = lane_state_q[l];
      lane_rid_d[l]   = lane_rid_q[l];
      lane_res_d[l]   = lane_res_q[l];
      case (lane_state_q[l])
        LANE_IDLE: begin
          if (lane_done[l]) err_d = 1'b1;
          if (issue_fire && (tgt_lane == LID_W'(l))) begin
            lane_state_d[l] = LANE_EXEC;
            lane_rid_d[l]   = gnt_idx;
          end
        end
        LANE_EXEC: begin
          if (lane_done[l]) begin
            lane_state_d[l] = LANE_HOLD;
            lane_res_d[l]   = lane_result[l*W +: W];
          end
        end
        LANE_HOLD: begin
          if (lane_done[l]) err_d = 1'b1;
          if (drain_fire && (drn_idx == LID_W'(l))) lane_state_d[l] = LANE_IDLE;
        end
        default: lane_state_d[l] = LANE_IDLE;
      endcase
    end
  end

  always_comb begin
    gnt_ptr_d     = gnt_ptr_q;
    drn_ptr_d     = drn_ptr_q;
    lane_valid_d  = '0;
    lane_opcode_d = lane_opcode_q;
    lane_is_fp_d  = lane_is_fp_q;
    lane_op1_d    = lane_op1_q;
    lane_op2_d    = lane_op2_q;
    if (issue_fire) begin
      gnt_ptr_d     = gnt_idx + RID_W'(1);
      lane_valid_d  = NUM_LANE'(1) << tgt_lane;
      lane_opcode_d = req_opcode[gnt_idx*6 +: 6];
      lane_is_fp_d  = req_is_fp[gnt_idx];
      lane_op1_d    = req_op1[gnt_idx*W +: W];
      lane_op2_d    = req_op2[gnt_idx*W +: W];
    end
    if (drain_fire) drn_ptr_d = drn_idx + LID_W'(1);
  end

  always_comb begin
    busy_cnt = '0;
    for (int l = 0; l < NUM_LANE; l++) begin
      if (lane_state_q[l] != LANE_IDLE) busy_cnt = busy_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < NUM_LANE; l++) begin
        lane_state_q[l] <= LANE_IDLE;
        lane_rid_q[l]   <= '0;
        lane_res_q[l]   <= '0;
      end
      gnt_ptr_q     <= '0;
      drn_ptr_q     <= '0;
      err_q         <= 1'b0;
      lane_valid_q  <= '0;
      lane_opcode_q <= '0;
      lane_is_fp_q  <= 1'b0;
      lane_op1_q    <= '0;
      lane_op2_q    <= '0;
    end else begin
      for (int l = 0; l < NUM_LANE; l++) begin
        lane_state_q[l] <= lane_state_d[l];
        lane_rid_q[l]   <= lane_rid_d[l];
        lane_res_q[l]   <= lane_res_d[l];
      end
      gnt_ptr_q     <= gnt_ptr_d;
      drn_ptr_q     <= drn_ptr_d;
      err_q         <= err_d;
      lane_valid_q  <= lane_valid_d;
      lane_opcode_q <= lane_opcode_d;
      lane_is_fp_q  <= lane_is_fp_d;
      lane_op1_q    <= lane_op1_d;
      lane_op2_q    <= lane_op2_d;
    end
  end

  assign lane_valid   = lane_valid_q;
  assign lane_opcode  = lane_opcode_q;
  assign lane_is_fp   = lane_is_fp_q;
  assign lane_op1     = lane_op1_q;
  assign lane_op2     = lane_op2_q;
  assign busy_count   = busy_cnt;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_thread_issue_arbiter.sv
// tb/tb_thread_issue_arbiter.sv - scoreboard bench for thread_issue_arbiter
module tb_thread_issue_arbiter;
  localparam int W = 32, NR = 4, NL = 4, RID_W = 2, LID_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR-1:0]    req_valid = '0, req_ready, req_is_fp = '0;
  logic [NR*6-1:0]  req_opcode = '0;
  logic [NR*W-1:0]  req_op1 = '0, req_op2 = '0;
  logic [NL-1:0]    lane_valid, lane_ready = '1, lane_done;
  logic [5:0]       lane_opcode;
  logic             lane_is_fp;
  logic [W-1:0]     lane_op1, lane_op2;
  logic [NL*W-1:0]  lane_result;
  logic             rsp_valid, rsp_ready = 1'b1;
  logic [W-1:0]     rsp_result;
  logic [RID_W-1:0] rsp_req_id;
  logic [LID_W-1:0] rsp_lane_id;
  logic [LID_W:0]   busy_count;
  logic             err_spurious;

  logic             auto_lane = 1'b0;
  logic [NL-1:0]    auto_done = '0, man_done = '0;
  logic [NL*W-1:0]  auto_res = '0, man_res = '0;
  int               n_vec = 0, n_err = 0;

  typedef struct packed {
    logic [NL-1:0] lv; logic [5:0] opc; logic fp; logic [W-1:0] a; logic [W-1:0] b;
  } iss_t;
  typedef struct packed {
    logic [W-1:0] res; logic [RID_W-1:0] rid; logic [LID_W-1:0] lid;
  } rsp_t;
  iss_t iss_q[$];
  rsp_t rsp_q[$];

  assign lane_done   = auto_lane ? auto_done : man_done;
  assign lane_result = auto_lane ? auto_res  : man_res;

  thread_issue_arbiter #(.W(W), .NUM_REQ(NR), .NUM_LANE(NL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_is_fp(req_is_fp), .req_op1(req_op1), .req_op2(req_op2),
    .lane_valid(lane_valid), .lane_opcode(lane_opcode), .lane_is_fp(lane_is_fp),
    .lane_op1(lane_op1), .lane_op2(lane_op2), .lane_ready(lane_ready),
    .lane_done(lane_done), .lane_result(lane_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_req_id(rsp_req_id), .rsp_lane_id(rsp_lane_id),
    .busy_count(busy_count), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Lane model: completes in the issue cycle with result op1+op2.
  always @(negedge clk) begin
    auto_done <= lane_valid;
    for (int i = 0; i < NL; i++)
      if (lane_valid[i]) auto_res[i*W +: W] <= lane_op1 + lane_op2;
  end

  // Monitor: every issue strobe and every response handshake pops the scoreboard.
  always @(negedge clk) begin
    iss_t ei;
    rsp_t er;
    if (lane_valid != '0) begin
      if (iss_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL issue_unexpected: got lane_valid %b expected none", lane_valid);
      end else begin
        ei = iss_q.pop_front();
        chk("issue", {lane_valid, lane_opcode, lane_is_fp, lane_op1, lane_op2}, ei);
      end
    end
    if (rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL rsp_unexpected: got lane %0d result %0h expected none", rsp_lane_id, rsp_result);
      end else begin
        er = rsp_q.pop_front();
        chk("response", {rsp_result, rsp_req_id, rsp_lane_id}, er);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [5:0] opc, input logic fp,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    req_opcode[r*6 +: 6] = opc;
    req_is_fp[r]         = fp;
    req_op1[r*W +: W]    = a;
    req_op2[r*W +: W]    = b;
  endtask

  function automatic logic [W-1:0] op_a(input int r); return W'(r * 16 + 1); endfunction
  function automatic logic [W-1:0] op_b(input int r); return W'(r + 100); endfunction

  function automatic iss_t exp_iss(input int lane, input int r);
    return {NL'(1) << lane, 6'(6'h10 + r), r[0], op_a(r), op_b(r)};
  endfunction

  function automatic rsp_t exp_rsp(input logic [W-1:0] res, input int r, input int lane);
    return {res, RID_W'(r), LID_W'(lane)};
  endfunction

  task automatic set_all();
    for (int r = 0; r < NR; r++) set_req(r, 6'(6'h10 + r), r[0], op_a(r), op_b(r));
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; req_valid = '0; man_done = '0; rsp_ready = 1'b1;
    auto_lane = 1'b0; lane_ready = '1;
    @(negedge clk);
    chk("reset_issue_side", {req_ready, lane_valid, lane_opcode, lane_is_fp, lane_op1, lane_op2}, '0);
    chk("reset_rsp_side", {rsp_valid, rsp_result, rsp_req_id, rsp_lane_id, busy_count}, '0);
    chk("reset_err", err_spurious, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Four grants in a row from requesters 0..3 onto lanes 0..3.
  task automatic fill4();
    set_all();
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) iss_q.push_back(exp_iss(k, k));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fill_req_ready", req_ready, NR'(1) << k);
      step();
    end
    req_valid = '0;
  endtask

  initial begin
    // Single request from requester 2.
    reset_dut();
    set_req(2, 6'h01, 1'b0, 32'd5, 32'd7);
    req_valid = 4'b0100;
    iss_q.push_back({4'b0001, 6'h01, 1'b0, 32'd5, 32'd7});
    @(negedge clk); chk("t1_req_ready", req_ready, 4'b0100);
    step(); req_valid = '0;
    @(negedge clk); chk("t1_busy_exec", busy_count, 3'd1);
    step(); man_done = 4'b0001; man_res[0 +: W] = 32'd12;
    rsp_q.push_back(exp_rsp(32'd12, 2, 0));
    step(); man_done = '0;
    @(negedge clk); chk("t1_rsp_valid", rsp_valid, 1'b1); chk("t1_busy_hold", busy_count, 3'd1);
    step();
    @(negedge clk); chk("t1_idle_after", {rsp_valid, busy_count}, 4'd0);

    // Continuous requests, instant lanes: grants 0,1,2,3,0.
    reset_dut();
    set_all(); auto_lane = 1'b1; req_valid = 4'b1111;
    iss_q.push_back(exp_iss(0, 0)); iss_q.push_back(exp_iss(1, 1));
    iss_q.push_back(exp_iss(2, 2)); iss_q.push_back(exp_iss(0, 3));
    iss_q.push_back(exp_iss(1, 0));
    rsp_q.push_back(exp_rsp(op_a(0) + op_b(0), 0, 0));
    rsp_q.push_back(exp_rsp(op_a(1) + op_b(1), 1, 1));
    rsp_q.push_back(exp_rsp(op_a(2) + op_b(2), 2, 2));
    rsp_q.push_back(exp_rsp(op_a(3) + op_b(3), 3, 0));
    rsp_q.push_back(exp_rsp(op_a(0) + op_b(0), 0, 1));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2_rr_grant", req_ready, NR'(1) << (k % 4));
      step();
    end
    req_valid = '0;
    repeat (4) step();
    @(negedge clk); chk("t2_drained", busy_count, 3'd0);

    // Spurious done and lane_ready gating.
    reset_dut();
    set_all(); lane_ready = '0; req_valid = 4'b0001;
    @(negedge clk); chk("t5_no_ready_lane", req_ready, 4'b0000);
    step(); lane_ready = 4'b1110;
    iss_q.push_back(exp_iss(1, 0));
    @(negedge clk); chk("t5_skip_unready", req_ready, 4'b0001);
    step(); req_valid = '0; lane_ready = '1; man_done = 4'b0100;
    step(); man_done = '0;
    @(negedge clk); chk("t5_err_set", err_spurious, 1'b1); chk("t5_no_rsp", rsp_valid, 1'b0);
    repeat (3) step();
    @(negedge clk); chk("t5_err_sticky", err_spurious, 1'b1); chk("t5_busy", busy_count, 3'd1);

    // All lanes busy, then lane 2 frees up.
    reset_dut();
    fill4();
    req_valid = 4'b0010;
    @(negedge clk); chk("t3_full_ready", req_ready, 4'b0000); chk("t3_busy4", busy_count, 3'd4);
    step(); man_done = 4'b0100; man_res[2*W +: W] = 32'hAB;
    rsp_q.push_back(exp_rsp(32'hAB, 2, 2));
    @(negedge clk); chk("t3_ready_exec", req_ready, 4'b0000);
    step(); man_done = '0;
    @(negedge clk); chk("t3_ready_hold", req_ready, 4'b0000);
    iss_q.push_back(exp_iss(2, 1));
    step();
    @(negedge clk); chk("t3_grant_after_drain", req_ready, 4'b0010);
    step(); req_valid = '0;
    @(negedge clk); chk("t3_busy_refill", busy_count, 3'd4);

    // Two lanes held with writeback stalled.
    reset_dut();
    fill4();
    rsp_ready = 1'b0; man_done = 4'b1010;
    man_res[1*W +: W] = 32'h11; man_res[3*W +: W] = 32'h33;
    step(); man_done = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_stall_stable", {rsp_valid, rsp_result, rsp_req_id, rsp_lane_id}, {1'b1, 32'h11, 2'd1, 2'd1});
      step();
    end
    rsp_q.push_back(exp_rsp(32'h11, 1, 1));
    rsp_q.push_back(exp_rsp(32'h33, 3, 3));
    rsp_ready = 1'b1;
    step();
    @(negedge clk); chk("t4_second_lane", rsp_lane_id, 2'd3);
    step();
    @(negedge clk); chk("t4_after_drain", {rsp_valid, busy_count}, {1'b0, 3'd2});

    // Async reset with two lanes EXEC and one HOLD.
    rsp_ready = 1'b0; man_done = 4'b0001; man_res[0 +: W] = 32'h55; req_valid = 4'b0001;
    iss_q.push_back(exp_iss(1, 0));
    step(); man_done = '0; req_valid = '0;
    @(negedge clk); chk("t6_busy3", busy_count, 3'd3); chk("t6_hold", rsp_valid, 1'b1);
    #2 rst_n = 1'b0; req_valid = 4'b1111;
    #1;
    chk("t6_async_issue", {req_ready, lane_valid, lane_opcode, lane_is_fp, lane_op1, lane_op2}, '0);
    chk("t6_async_rsp", {rsp_valid, rsp_result, rsp_req_id, rsp_lane_id, busy_count}, '0);
    @(posedge clk); #1 rst_n = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    step(); man_done = 4'b0110;
    step(); man_done = '0;
    repeat (3) begin
      @(negedge clk); chk("t6_no_stale_rsp", {rsp_valid, busy_count}, 4'd0);
      step();
    end

    chk("iss_queue_empty", iss_q.size(), 0);
    chk("rsp_queue_empty", rsp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/thread_issue_arbiter.md
Name: thread_issue_arbiter

Overview:
- Shares a pool of NUM_LANE cuda_thread lanes between NUM_REQ instruction requesters (warp slots from the NoC dispatcher).
- Round-robin grants one request per cycle and issues it to the lowest-index free lane.
- Tracks each lane from issue through completion and captures its result.
- Drains results round-robin to the writeback unit, tagged with requester and lane IDs.

Parameters:
- W, 32, operand/result width
- NUM_REQ, 4, number of requesters (power of 2, ≥2)
- NUM_LANE, 4, number of cuda_thread lanes (power of 2, ≥2)
- RID_W, $clog2(NUM_REQ), requester ID width
- LID_W, $clog2(NUM_LANE), lane ID width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester instruction valid
- req_ready  out  NUM_REQ  per-requester accept; combinational one-hot grant
- req_opcode  in  NUM_REQ*6  PTX opcodes; requester i occupies slice [i*6 +: 6]
- req_is_fp  in  NUM_REQ  0=ALU, 1=FPU
- req_op1  in  NUM_REQ*W  operand 1, sliced as for req_opcode
- req_op2  in  NUM_REQ*W  operand 2
- lane_valid  out  NUM_LANE  registered one-hot issue strobe to lane valid_in
- lane_opcode  out  6  registered broadcast opcode
- lane_is_fp  out  1  registered broadcast is_fp
- lane_op1  out  W  registered broadcast operand 1
- lane_op2  out  W  registered broadcast operand 2
- lane_ready  in  NUM_LANE  lane ready_out
- lane_done  in  NUM_LANE  lane done_out
- lane_result  in  NUM_LANE*W  lane result_out, sliced per lane
- rsp_valid  out  1  result available
- rsp_ready  in  1  writeback accepts result
- rsp_result  out  W  result data
- rsp_req_id  out  RID_W  requester that issued the instruction
- rsp_lane_id  out  LID_W  lane that executed it
- busy_count  out  LID_W+1  number of lanes not IDLE
- err_spurious  out  1  sticky: lane_done seen on a lane not in EXEC

Behaviour:
- Reset (rst_n=0, async):
  - all lanes IDLE; grant pointer and drain pointer = 0.
  - lane_valid=0, lane_opcode/is_fp/op1/op2=0.
  - rsp_valid=0, rsp_result/rsp_req_id/rsp_lane_id=0.
  - busy_count=0, err_spurious=0, req_ready=0.
  - Reset mid-operation discards all in-flight and held results; no response is produced for them.
- Per-lane FSM:
  - IDLE→EXEC on issue. Issue requires lane IDLE && lane_ready=1.
  - EXEC→HOLD when lane_done=1: capture lane_result and the stored requester ID in the same edge.
  - HOLD→IDLE when that lane is the drained lane and rsp_valid && rsp_ready.
  - A lane returning to IDLE is issuable at the earliest in the following cycle.
- Grant:
  - Eligible when at least one lane is IDLE with lane_ready=1.
  - Requester chosen round-robin among req_valid bits, starting at the grant pointer. After a grant to requester i, the pointer moves to (i+1) mod NUM_REQ.
  - req_ready[grant]=1 for that cycle only; all other bits 0. With no eligible lane, req_ready is all 0 and the pointer holds.
  - Target lane = lowest-index IDLE lane with lane_ready=1.
- Issue timing:
  - Grant at edge T: lane_valid[target]=1 and broadcast operand registers loaded, visible in cycle T+1 for exactly one cycle.
  - Lane marked EXEC at edge T. busy_count updates at the same edge.
  - At most one issue per cycle.
- Drain:
  - rsp_valid = any lane in HOLD.
  - Selected lane = first HOLD lane at or after the drain pointer (round-robin). rsp_* are a combinational mux of that lane's held registers.
  - On handshake the drain pointer becomes (lane+1) mod NUM_LANE.
  - rsp_* must stay stable while rsp_valid && !rsp_ready, unless an earlier-priority lane newly enters HOLD. The drain pointer only moves on handshake, so the selection does not change.
- Simultaneous events: several lanes asserting lane_done in one cycle are all captured. The same lane cannot drain and be reissued in one cycle.
- lane_done on an IDLE or HOLD lane is ignored and sets err_spurious. err_spurious is cleared only by reset.
- busy_count = number of lanes in EXEC or HOLD, range 0..NUM_LANE.

Test Plan:
- Reset, then requester 2 sends opcode 6'h01, op1=5, op2=7 → req_ready=4'b0100 that cycle; next cycle lane_valid=4'b0001 with lane_op1=5 and lane_op2=7; after lane 0 done with result 12 → rsp_valid, rsp_result=12, rsp_req_id=2, rsp_lane_id=0.
- All 4 requesters valid continuously, lanes respond instantly → grants follow order 0,1,2,3,0; each lane_valid is a single-cycle one-hot.
- 4 lanes in EXEC, requester 1 valid → req_ready=0 and busy_count=4; lane 2 completes and drains → grant the cycle after the drain, issued to lane 2.
- Lanes 1 and 3 done in the same cycle, rsp_ready held 0 for 5 cycles → rsp stays on lane 1 unchanged; raising rsp_ready drains lane 1 then lane 3 on consecutive cycles.
- lane_done[2]=1 while lane 2 is IDLE → err_spurious=1 and stays set; no rsp_valid generated.
- Two lanes EXEC and one HOLD, then rst_n pulsed low asynchronously mid-cycle → all outputs 0 immediately, busy_count=0; a later lane_done does not produce a response.
